// File: rtl/mmt_matrix_loader.sv
// Packs the 32-matrix element stream into one row word per SRAM write; a write issues the cycle after a row's last element.
// No backpressure: the stream is consumed every in_valid cycle, and dropping in_valid mid-load discards the partial row and returns to idle.
module mmt_matrix_loader #(
    parameter int N_MAT   = 32,
    parameter int MAX_DIM = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    input  logic [7:0]                                matrix,
    input  logic [1:0]                                matrix_size,
    output logic                                      sram_web,
    output logic [$clog2(N_MAT)+$clog2(MAX_DIM)-1:0] sram_addr,
    output logic [MAX_DIM*8-1:0]                      sram_wdata,
    output logic [1:0]                                size_code,
    output logic                                      load_done
);
    localparam int IDX_W = $clog2(N_MAT);
    localparam int DIM_W = $clog2(MAX_DIM);
    localparam int W     = MAX_DIM * 8;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           size_q, size_d;
    logic [DIM_W-1:0]     col_q, col_d, row_q, row_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [W-1:0]         buf_q, buf_d, wdata_q, wdata_d, row_cur;
    logic [IDX_W+DIM_W-1:0] addr_q, addr_d;
    logic                 web_q, web_d;
    logic [DIM_W-1:0]     nm1;
    logic                 row_end, mat_end, last_elem;

    assign nm1       = DIM_W'((32'd2 << size_q) - 32'd1);
    assign row_end   = (col_q == nm1);
    assign mat_end   = row_end && (row_q == nm1);
    assign last_elem = mat_end && (idx_q == IDX_W'(N_MAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            size_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            web_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            col_q   <= col_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            web_q   <= web_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: state_d = in_valid ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                if (!in_valid)      state_d = ST_IDLE;
                else if (last_elem) state_d = ST_DONE;
            end
            default:            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        size_d  = size_q;
        col_d   = col_q;
        row_d   = row_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        web_d   = 1'b1;
        row_cur = buf_q;
        row_cur[int'(col_q)*8 +: 8] = matrix;
        case (state_q)
            ST_LOAD: begin
                if (!in_valid) begin
                    // Abort: partial row is dropped, size_code keeps its value.
                    col_d = '0;
                    row_d = '0;
                    idx_d = '0;
                    buf_d = '0;
                end else if (row_end) begin
                    wdata_d = row_cur;
                    addr_d  = {idx_q, row_q};
                    web_d   = 1'b0;
                    buf_d   = '0;
                    col_d   = '0;
                    if (mat_end) begin
                        row_d = '0;
                        idx_d = idx_q + 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    buf_d = row_cur;
                    col_d = col_q + 1'b1;
                end
            end
            default: begin
                // Element (0,0) of matrix 0 arrives on the same cycle the load starts.
                if (in_valid) begin
                    size_d = matrix_size;
                    buf_d  = {{(W-8){1'b0}}, matrix};
                    col_d  = DIM_W'(1);
                    row_d  = '0;
                    idx_d  = '0;
                end
            end
        endcase
    end

    always_comb begin
        load_done = (state_q == ST_DONE);
    end

    assign sram_web   = web_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign size_code  = size_q;
endmodule

// File: tb/tb_mmt_matrix_loader.sv
// Directed bench for mmt_matrix_loader: full loads at several sizes, abort, reset mid-load and back-to-back loads.
module tb_mmt_matrix_loader;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   matrix = '0;
    logic [1:0]   matrix_size = '0;
    logic         sram_web;
    logic [8:0]   sram_addr;
    logic [127:0] sram_wdata;
    logic [1:0]   size_code;
    logic         load_done;

    int checks = 0;
    int errors = 0;

    logic [8:0]   wr_addr [0:2047];
    logic [127:0] wr_data [0:2047];
    int           wr_cyc  [0:2047];
    int           wr_cnt = 0;
    int           done_cnt = 0;
    logic         done_web;
    logic [8:0]   done_addr;
    int           cyc = 0;

    mmt_matrix_loader #(.N_MAT(32), .MAX_DIM(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .matrix     (matrix),
        .matrix_size(matrix_size),
        .sram_web   (sram_web),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .size_code  (size_code),
        .load_done  (load_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n && sram_web === 1'b0 && wr_cnt < 2048) begin
            wr_addr[wr_cnt] = sram_addr;
            wr_data[wr_cnt] = sram_wdata;
            wr_cyc[wr_cnt]  = cyc;
            wr_cnt = wr_cnt + 1;
        end
        if (rst_n && load_done === 1'b1) begin
            done_cnt  = done_cnt + 1;
            done_web  = sram_web;
            done_addr = sram_addr;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    // mode 0: values 1,2,3..; mode 1: index mod 256; mode 2: 0xFF everywhere
    task automatic feed(input logic [1:0] sz, input int nelem, input int mode, input int tail);
        for (int i = 0; i < nelem; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            case (mode)
                0:       matrix = 8'(i + 1);
                1:       matrix = 8'(i);
                default: matrix = 8'hFF;
            endcase
            matrix_size = (i == 0) ? sz : 2'bxx;
        end
        @(posedge clk); #1;
        in_valid    = 1'b0;
        matrix      = '0;
        matrix_size = '0;
        repeat (tail) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (sram_web !== 1'b1) begin errors++; $display("FAIL reset_web got %b exp 1", sram_web); end
        checks++; if (sram_addr !== 9'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", sram_addr); end
        checks++; if (sram_wdata !== 128'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", sram_wdata); end
        checks++; if (size_code !== 2'd0) begin errors++; $display("FAIL reset_size got %0d exp 0", size_code); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", load_done); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_n2_full();
        int base, d0, bad;
        base = wr_cnt; d0 = done_cnt;
        feed(2'd0, 128, 0, 3);
        checks++; if (wr_cnt - base != 64) begin errors++; $display("FAIL n2_count got %0d exp 64", wr_cnt - base); end
        checks++; if (wr_addr[base] !== 9'h000 || wr_data[base] !== 128'h0201) begin errors++; $display("FAIL n2_w0 got %h/%h exp 000/0201", wr_addr[base], wr_data[base]); end
        checks++; if (wr_addr[base+1] !== 9'h001 || wr_data[base+1] !== 128'h0403) begin errors++; $display("FAIL n2_w1 got %h/%h exp 001/0403", wr_addr[base+1], wr_data[base+1]); end
        checks++; if (wr_addr[base+2] !== 9'h010 || wr_data[base+2] !== 128'h0605) begin errors++; $display("FAIL n2_w2 got %h/%h exp 010/0605", wr_addr[base+2], wr_data[base+2]); end
        checks++; if (wr_cyc[base+1] - wr_cyc[base] != 2) begin errors++; $display("FAIL n2_spacing got %0d exp 2", wr_cyc[base+1] - wr_cyc[base]); end
        checks++; if (wr_addr[base+63] !== 9'h1F1 || wr_data[base+63] !== 128'h807F) begin errors++; $display("FAIL n2_last got %h/%h exp 1f1/807f", wr_addr[base+63], wr_data[base+63]); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL n2_done_cnt got %0d exp 1", done_cnt - d0); end
        checks++; if (done_web !== 1'b0 || done_addr !== 9'h1F1) begin errors++; $display("FAIL n2_done_align got %b/%h exp 0/1f1", done_web, done_addr); end
        checks++; if (size_code !== 2'd0) begin errors++; $display("FAIL n2_size got %0d exp 0", size_code); end
        bad = 0;
        for (int k = 0; k < 64; k++)
            if (wr_addr[base+k] !== 9'((k / 2) * 16 + (k % 2))) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL n2_addr_seq got %0d bad exp 0", bad); end
    endtask

    task automatic test_n16();
        int base, d0, bad;
        logic [127:0] exp;
        base = wr_cnt; d0 = done_cnt;
        feed(2'd3, 8192, 1, 3);
        checks++; if (wr_cnt - base != 512) begin errors++; $display("FAIL n16_count got %0d exp 512", wr_cnt - base); end
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            for (int j = 0; j < 16; j++) exp[8*j +: 8] = 8'((16 * k + j) % 256);
            if (wr_addr[base+k] !== 9'(k) || wr_data[base+k] !== exp) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL n16_words got %0d bad exp 0", bad); end
        checks++; if (wr_cyc[base+1] - wr_cyc[base] != 16) begin errors++; $display("FAIL n16_spacing got %0d exp 16", wr_cyc[base+1] - wr_cyc[base]); end
        checks++; if (done_cnt - d0 != 1 || done_addr !== 9'h1FF || done_web !== 1'b0) begin errors++; $display("FAIL n16_done got %0d/%h exp 1/1ff", done_cnt - d0, done_addr); end
        checks++; if (size_code !== 2'd3) begin errors++; $display("FAIL n16_size got %0d exp 3", size_code); end
    endtask

    task automatic test_neg_fill();
        int base, bad;
        base = wr_cnt;
        feed(2'd1, 512, 2, 3);
        checks++; if (wr_cnt - base != 128) begin errors++; $display("FAIL neg_count got %0d exp 128", wr_cnt - base); end
        bad = 0;
        for (int k = 0; k < 128; k++)
            if (wr_data[base+k] !== 128'hFFFF_FFFF || wr_addr[base+k] !== 9'((k / 4) * 16 + (k % 4))) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL neg_words got %0d bad exp 0", bad); end
    endtask

    task automatic test_abort();
        int base, d0;
        base = wr_cnt; d0 = done_cnt;
        feed(2'd2, 100, 0, 4);
        checks++; if (wr_cnt - base != 12) begin errors++; $display("FAIL abort_count got %0d exp 12", wr_cnt - base); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_done got %0d exp 0", done_cnt - d0); end
        checks++; if (size_code !== 2'd2) begin errors++; $display("FAIL abort_size_held got %0d exp 2", size_code); end
        base = wr_cnt; d0 = done_cnt;
        feed(2'd0, 128, 0, 3);
        checks++; if (wr_addr[base] !== 9'h000 || wr_data[base] !== 128'h0201) begin errors++; $display("FAIL abort_next_w0 got %h/%h exp 000/0201", wr_addr[base], wr_data[base]); end
        checks++; if (size_code !== 2'd0 || done_cnt - d0 != 1) begin errors++; $display("FAIL abort_next got size %0d done %0d exp 0/1", size_code, done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        int base, d0;
        base = wr_cnt; d0 = done_cnt;
        for (int i = 0; i < 37; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            matrix = 8'(i + 1);
            matrix_size = (i == 0) ? 2'd1 : 2'bxx;
        end
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; matrix = '0; matrix_size = '0;
        #1;
        checks++; if (sram_web !== 1'b1 || sram_addr !== 9'h0 || sram_wdata !== 128'h0 || size_code !== 2'd0 || load_done !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got %b/%h/%h/%0d/%b exp 1/0/0/0/0", sram_web, sram_addr, sram_wdata, size_code, load_done);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        checks++; if (wr_cnt - base != 9 || done_cnt != d0) begin errors++; $display("FAIL midrst_writes got %0d/%0d exp 9/0", wr_cnt - base, done_cnt - d0); end
        test_n2_full();
    endtask

    task automatic test_back_to_back();
        int base, d0;
        base = wr_cnt; d0 = done_cnt;
        feed(2'd3, 8192, 1, 0);
        feed(2'd0, 128, 0, 3);
        checks++; if (wr_cnt - base != 576) begin errors++; $display("FAIL b2b_count got %0d exp 576", wr_cnt - base); end
        checks++; if (wr_addr[base+512] !== 9'h000 || wr_data[base+512] !== 128'h0201) begin errors++; $display("FAIL b2b_first got %h/%h exp 000/0201", wr_addr[base+512], wr_data[base+512]); end
        checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done got %0d exp 2", done_cnt - d0); end
        checks++; if (size_code !== 2'd0) begin errors++; $display("FAIL b2b_size got %0d exp 0", size_code); end
    endtask

    initial begin
        test_reset();
        test_n2_full();
        test_n16();
        test_neg_fill();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
